// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: assembles big-endian 32-bit words and writes them to instruction RAM until HALT_WORD.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the checksum_err output.
module instr_mem_loader #(
  parameter int                   RAM_WIDTH  = 32,
  parameter int                   RAM_DEPTH  = 2048,
  parameter int                   ADDR_WIDTH = 11,
  parameter logic [RAM_WIDTH-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [RAM_WIDTH-1:0]  dina,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic                  checksum_err
`endif
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
`ifdef LOADER_CHECKSUM_EN
    CHECK = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [23:0] shift_q;
  logic [1:0]  byte_idx;
  logic [31:0] word_nxt;
  logic        restart, halt_wr, accept, word_cmp, full;

  assign word_nxt = {shift_q, byte_in};
  assign restart  = start && (state == IDLE || state == DONE);
  // Bytes arriving while the halt word is being written belong to the checksum, never to a new word.
  assign halt_wr  = wea && (dina == HALT_WORD);
  assign accept   = (state == LOAD) && byte_valid && !halt_wr;
  assign word_cmp = accept && (byte_idx == 2'd3);
  assign full     = (word_count == DEPTH_CNT);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       check_byte;
  assign check_byte = byte_valid && ((state == CHECK) || (state == LOAD && halt_wr));
`endif

  always_ff @(posedge clka) begin
    if (rsta) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD: begin
        if (word_cmp && full) begin
          state_nxt = DONE;
        end else if (halt_wr) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = byte_valid ? DONE : CHECK;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (byte_valid) state_nxt = DONE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == LOAD);
`ifdef LOADER_CHECKSUM_EN
    busy = busy || (state == CHECK);
`endif
    done = (state == DONE);
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      wea        <= 1'b0;
      addra      <= '0;
      dina       <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      shift_q    <= '0;
      byte_idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
      checksum_err <= 1'b0;
`endif
    end else begin
      wea <= 1'b0;
      if (restart) begin
        addra      <= '0;
        word_count <= '0;
        overflow   <= 1'b0;
        shift_q    <= '0;
        byte_idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum         <= '0;
        checksum_err <= 1'b0;
`endif
      end else begin
        // Address saturates at the last word so it can never wrap back onto written code.
        if (wea) begin
          word_count <= word_count + 1'b1;
          if (addra != LAST_ADDR) addra <= addra + 1'b1;
        end
        if (accept) begin
          shift_q  <= word_nxt[23:0];
          byte_idx <= byte_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum <= csum ^ byte_in;
`endif
          if (byte_idx == 2'd3) begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              wea  <= 1'b1;
              dina <= RAM_WIDTH'(word_nxt);
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        if (check_byte) checksum_err <= (byte_in != csum);
`endif
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: load, back-to-back, restart, reset mid-word, overflow, optional checksum.
module tb_instr_mem_loader;

  logic        clka = 1'b0;
  logic        rsta = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        wea;
  logic [10:0] addra;
  logic [31:0] dina;
  logic        busy, done, overflow;
  logic [11:0] word_count;
`ifdef LOADER_CHECKSUM_EN
  logic        checksum_err;
`endif

  instr_mem_loader dut (
    .clka(clka), .rsta(rsta), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .wea(wea), .addra(addra), .dina(dina), .busy(busy), .done(done),
    .word_count(word_count), .overflow(overflow)
`ifdef LOADER_CHECKSUM_EN
    , .checksum_err(checksum_err)
`endif
  );

  always #5 clka = ~clka;

  int checks = 0;
  int errors = 0;

  logic [10:0] wr_a [8192];
  logic [31:0] wr_d [8192];
  int          nwr = 0;

  always @(negedge clka) begin
    if (wea && nwr < 8192) begin
      wr_a[nwr] = addra;
      wr_d[nwr] = dina;
      nwr++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clka);
  endtask

  task automatic drive(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clka);
  endtask

  task automatic drive_word(input logic [31:0] w);
    drive(w[31:24]); drive(w[23:16]); drive(w[15:8]); drive(w[7:0]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clka);
    start = 1'b0;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_wea"}, wea, 0);
    chk({pfx, "_addra"}, addra, 0);
    chk({pfx, "_dina"}, dina, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_wcnt"}, word_count, 0);
    chk({pfx, "_ovf"}, overflow, 0);
  endtask

  int base;
  int bad;

  initial begin
    tick(3);
    check_zero("rst");
    rsta = 1'b0;
    tick(1);

    // Basic program: one instruction then halt
    base = nwr;
    pulse_start();
    chk("s1_busy", busy, 1);
    drive_word(32'h20080005);
    drive_word(32'hFFFFFFFF);
    byte_valid = 1'b0;
    chk("s1_wea_last", wea, 1);
    chk("s1_done_during_wea", done, 0);
    tick(1);
    chk("s1_wea_drop", wea, 0);
    chk("s1_done", done, 1);
    chk("s1_busy_done", busy, 0);
    tick(2);
    chk("s1_nwr", nwr - base, 2);
    chk("s1_a0", wr_a[base], 0);
    chk("s1_d0", wr_d[base], 32'h20080005);
    chk("s1_a1", wr_a[base+1], 1);
    chk("s1_d1", wr_d[base+1], 32'hFFFFFFFF);
    chk("s1_wcnt", word_count, 2);

    // Bytes in DONE are ignored
    drive_word(32'h01020304);
    byte_valid = 1'b0;
    tick(2);
    chk("done_ign_wcnt", word_count, 2);
    chk("done_ign_nwr", nwr - base, 2);
    chk("done_held", done, 1);

    // Restart from DONE, back-to-back bytes, start ignored in LOAD
    base = nwr;
    pulse_start();
    chk("rs_wcnt", word_count, 0);
    chk("rs_busy", busy, 1);
    chk("rs_done", done, 0);
    for (int i = 0; i < 8; i++) drive(8'(i));
    byte_valid = 1'b0;
    tick(2);
    pulse_start();
    tick(1);
    chk("ld_start_wcnt", word_count, 2);
    chk("ld_start_busy", busy, 1);
    drive_word(32'hFFFFFFFF);
    byte_valid = 1'b0;
    tick(3);
    chk("b2b_nwr", nwr - base, 3);
    chk("b2b_d0", wr_d[base], 32'h00010203);
    chk("b2b_a0", wr_a[base], 0);
    chk("b2b_d1", wr_d[base+1], 32'h04050607);
    chk("b2b_a1", wr_a[base+1], 1);
    chk("b2b_a2", wr_a[base+2], 2);
    chk("b2b_wcnt", word_count, 3);

    // Reset mid-word, with start and byte_valid in the same cycle
    pulse_start();
    drive(8'hAA); drive(8'hBB);
    rsta = 1'b1; start = 1'b1; byte_in = 8'hCC; byte_valid = 1'b1;
    tick(1);
    check_zero("midrst");
    rsta = 1'b0; start = 1'b0;
    drive(8'hDD);
    byte_valid = 1'b0;
    tick(1);
    chk("idle_ign_busy", busy, 0);
    chk("idle_ign_wcnt", word_count, 0);
    base = nwr;
    pulse_start();
    drive_word(32'h11223344);
    drive_word(32'hFFFFFFFF);
    byte_valid = 1'b0;
    tick(3);
    chk("post_rst_nwr", nwr - base, 2);
    chk("post_rst_d0", wr_d[base], 32'h11223344);
    chk("post_rst_a0", wr_a[base], 0);

    // Overflow: RAM_DEPTH + 1 non-halt words
    base = nwr;
    pulse_start();
    for (int i = 0; i <= 2048; i++) drive_word(32'h5A000000 | 32'(i));
    byte_valid = 1'b0;
    tick(3);
    chk("ovf_nwr", nwr - base, 2048);
    bad = 0;
    for (int i = 0; i < 2048; i++)
      if (wr_a[base+i] !== 11'(i) || wr_d[base+i] !== (32'h5A000000 | 32'(i))) bad++;
    chk("ovf_seq_bad", bad, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_done", done, 1);
    chk("ovf_wcnt", word_count, 2048);
    chk("ovf_addra", addra, 11'd2047);
    pulse_start();
    chk("ovf_clr", overflow, 0);
    chk("ovf_clr_addra", addra, 0);
    drive_word(32'hFFFFFFFF);
    byte_valid = 1'b0;
    tick(3);

`ifdef LOADER_CHECKSUM_EN
    // Checksum pass then fail; the checksum byte is never written
    for (int k = 0; k < 2; k++) begin
      base = nwr;
      pulse_start();
      drive_word(32'h01020304);
      drive_word(32'hFFFFFFFF);
      byte_valid = 1'b0;
      tick(2);
      chk("cs_busy_check", busy, 1);
      chk("cs_done_check", done, 0);
      drive(k == 0 ? 8'h04 : 8'h05);
      byte_valid = 1'b0;
      tick(2);
      chk("cs_done", done, 1);
      chk("cs_err", checksum_err, k == 0 ? 1'b0 : 1'b1);
      chk("cs_nwr", nwr - base, 2);
      chk("cs_wcnt", word_count, 2);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
